// File: rtl/mux41c_rr_arbiter_pkg.sv
// Shared types and constants for the mux41c round-robin arbiter.
//   NREQ     : number of requesters sharing the mux41c path
//   SEL_W    : width of the mux select
//   arb_state_t : arbiter FSM states
//   sel_onehot  : select index -> one-hot grant vector
package mux_arb_pkg;

  localparam int NREQ  = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    SWITCH = 2'd2
  } arb_state_t;

  function automatic logic [NREQ-1:0] sel_onehot(input logic [SEL_W-1:0] idx);
    logic [NREQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux41c_rr_arbiter_rr_pick4.sv
// rr_pick4: combinational rotating-priority encoder.
//   req[3:0] : request vector
//   ptr[1:0] : index searched first; search order ptr, ptr+1, ptr+2, ptr+3 (mod 4)
//   idx[1:0] : first requesting index in that order (ptr when none)
//   any      : at least one request bit set
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  logic             found;
  logic [SEL_W-1:0] cand;

  always_comb begin
    idx   = ptr;
    found = 1'b0;
    cand  = ptr;
    any   = |req;
    for (int k = 0; k < NREQ; k++) begin
      // Index arithmetic wraps naturally in SEL_W bits.
      cand = ptr + SEL_W'(k);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux41c_rr_arbiter.sv
// mux41c_rr_arbiter: round-robin arbiter sharing one mux41c 4:1 path.
//   clk          : system clock, rising edge
//   reset        : asynchronous active-high reset
//   req[3:0]     : level requests, bit i <-> mux input c[i]
//   gnt[3:0]     : registered one-hot grant, zero when no owner
//   sel[1:0]     : registered mux select, drives mux41c.s
//   valid        : registered, high while a grant is active (qualifies y)
//   dbg_state    : FSM state
//   dbg_ptr      : current highest-priority index
//   dbg_hold_cnt : cycles the current owner has held the grant (saturating)
//
// Handshake: req is a level; a requester is served while req[i] is high and
// gnt[i]/valid are high. Dropping req[owner] releases the path; the arbiter
// then spends exactly one cycle with valid low before any new owner.
module mux41c_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int HOLD_MAX = 8,
  localparam int CNT_W = $clog2(HOLD_MAX + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic [SEL_W-1:0] sel,
  output logic             valid,
  output arb_state_t       dbg_state,
  output logic [SEL_W-1:0] dbg_ptr,
  output logic [CNT_W-1:0] dbg_hold_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_MAX);

  arb_state_t       state_q, state_d;
  logic [SEL_W-1:0] owner_q, owner_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             valid_q, valid_d;

  logic [SEL_W-1:0] pick_idx;
  logic             pick_any;
  logic             others_pending;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign others_pending = |(req & ~sel_onehot(owner_q));

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    valid_d    = valid_q;
    case (state_q)
      IDLE, SWITCH: begin
        gnt_d   = '0;
        valid_d = 1'b0;
        if (pick_any) begin
          state_d    = GRANT;
          owner_d    = pick_idx;
          sel_d      = pick_idx;
          gnt_d      = sel_onehot(pick_idx);
          valid_d    = 1'b1;
          hold_cnt_d = CNT_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        // Release and preempt collapse into the same single SWITCH cycle.
        if (!req[owner_q] || ((hold_cnt_q == CNT_MAX) && others_pending)) begin
          state_d    = SWITCH;
          gnt_d      = '0;
          valid_d    = 1'b0;
          ptr_d      = owner_q + SEL_W'(1);  // previous owner goes last
          hold_cnt_d = '0;
        end else if (hold_cnt_q != CNT_MAX) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      sel_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      valid_q    <= valid_d;
    end
  end

  assign gnt          = gnt_q;
  assign sel          = sel_q;
  assign valid        = valid_q;
  assign dbg_state    = state_q;
  assign dbg_ptr      = ptr_q;
  assign dbg_hold_cnt = hold_cnt_q;

endmodule

// File: doc/mux41c_rr_arbiter.md
# mux41c_rr_arbiter

Round-robin arbiter that shares one 4:1 mux path (the `mux41c` datapath) among four requesters. It drives the mux select `s` and a one-hot grant, and qualifies the mux output `y` with `valid`. A grant is held while its owner keeps requesting, for at most `HOLD_MAX` cycles when others are waiting. Each ownership change inserts a one-cycle turnaround gap so consumers never sample a mid-switch `y`.

## Interface
- `HOLD_MAX`, default 8: maximum grant cycles before forced rotation while other requests are pending; legal range ≥ 1.
- `clk`  input  1  single system clock; all state changes on its rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `req`  input  4  level request per requester; bit i corresponds to mux input `c[i]`.
- `gnt`  output  4  one-hot grant, registered; all zero when no owner.
- `sel`  output  2  mux select; connects to `mux41c.s`; registered.
- `valid`  output  1  high while a grant is active; qualifies `y`.

## Operation
- Three states: IDLE, GRANT, SWITCH.
- Internal registers: `state`, `owner[1:0]`, `ptr[1:0]` (highest-priority index), and `hold_cnt` of width `$clog2(HOLD_MAX+1)`.
- Winner selection uses rotating priority: search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4), and the first set `req` bit wins.
- IDLE:
  - Outputs: `gnt`=0, `valid`=0.
  - If any `req` bit is set, go to GRANT with `owner`=winner, `sel`=winner, `gnt`=1<<winner, `valid`=1, `hold_cnt`=1.
- GRANT:
  - `hold_cnt` increments each cycle and saturates at `HOLD_MAX`.
  - Go to SWITCH when `req[owner]`=0 (release).
  - Also go to SWITCH when `hold_cnt`==`HOLD_MAX` and any other `req` bit is set (preempt).
  - If `hold_cnt`==`HOLD_MAX` and no other request is pending, stay in GRANT, counter saturated.
- SWITCH (exactly one cycle):
  - `gnt`=0, `valid`=0, and `sel` holds the previous owner.
  - `ptr` becomes owner+1 (mod 4), so the previous owner gets lowest priority.
  - Next cycle: if any `req` bit is set, go to GRANT with the winner chosen from the new `ptr`; otherwise go to IDLE.
- Release and preempt in the same cycle behave identically: one SWITCH.
- A requester that drops `req` while not owner is simply not considered; there is no request latching.

## Timing
- All outputs are registered; no combinational path from `req` to any output.
- Grant latency: `req` sampled high at edge k in IDLE gives `gnt`/`sel`/`valid` updated after edge k (1 cycle).
- Release latency: `req[owner]` sampled low at edge k gives `valid`=0 after edge k. The next grant, if requests are pending, follows after edge k+1.
- Owner-change gap is exactly one cycle with `valid`=0.
- Under full load, each owner holds for `HOLD_MAX` cycles followed by a 1-cycle gap, so the period is 4·(`HOLD_MAX`+1).
- `ptr` wraps from 3 to 0.
- Reset (asynchronous, takes effect without a clock edge):
  - state=IDLE, `gnt`=0, `sel`=0, `valid`=0, `ptr`=0, `owner`=0, `hold_cnt`=0.
  - Reset during GRANT drops `gnt`/`valid` immediately.
  - First grant after reset release follows the IDLE rule with `ptr`=0.

## Structure
- Package `mux_arb_pkg`:
  - `NREQ`=4, `SEL_W`=2.
  - State enum `arb_state_t` {IDLE, GRANT, SWITCH}.
- Sub-module `rr_pick4`: combinational rotating-priority encoder.
  - Inputs `req[3:0]`, `ptr[1:0]`.
  - Outputs `idx[1:0]`, `any`.
  - Instantiated once in the arbiter.
- Top-level integration: `sel` drives `mux41c.s`; the consumer gates `y` with `valid`.

## Test plan
- Reset: assert `reset` mid-run with `req`=1111 → `gnt`=0000, `sel`=00, `valid`=0 with no clock edge; after release, first grant goes to index 0.
- Single requester: `req`=0100 from cycle 3 → after next edge `gnt`=0100, `sel`=10, `valid`=1. Drop `req` at cycle 8 → one SWITCH cycle with `valid`=0, then IDLE.
- Full load with `HOLD_MAX`=4 and `req`=1111 held → grant sequence 0,1,2,3,0. Each grant lasts 4 cycles of `valid`=1 followed by a 1-cycle gap; `sel` tracks the owner.
- Lone owner past limit with `HOLD_MAX`=2: `req`=0010 for 10 cycles → `gnt`=0010 continuously, no SWITCH, `hold_cnt` saturated at 2.
- Rotation fairness: owner 1 releases while `req`=1001 → SWITCH sets `ptr`=2, and the next grant goes to 3 (`gnt`=1000, `sel`=11), not 0.
- Preempt vs. release coincidence with `HOLD_MAX`=3: owner 0 drops `req` on the same cycle its `hold_cnt` hits 3, with `req[2]`=1 → exactly one SWITCH cycle, then `gnt`=0100.
